// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response, execute redirect and decode handoff.
// master is the fetch unit side; slave is the memory/execute/decode side.
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: credit-limited sequential requests, PC-tagged 2-entry response FIFO,
// and redirect flush that discards every response still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);

  logic        active;
  logic [31:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop_cnt;
  logic [1:0]  count;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] tag_q     [2];
  logic        tag_rd;
  logic        tag_wr;

  logic        inst_valid_c;
  logic        req_valid_c;
  logic        req_fire;
  logic        pop;
  logic        push;
  logic        rsp_drop;
  logic [2:0]  occ;
  logic        unused_redirect_bits;

  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  always_comb begin
    inst_valid_c = (count != 2'd0) && !bus.redirect_valid;
    pop          = inst_valid_c && bus.inst_ready;
    // Slots already promised (in flight or buffered) minus the one leaving this cycle.
    occ          = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
    req_valid_c  = active && !bus.redirect_valid && (occ < 3'd2);
    req_fire     = req_valid_c && bus.imem_req_ready;
    rsp_drop     = (drop_cnt != 2'd0);
    push         = bus.imem_rsp_valid && !rsp_drop && !bus.redirect_valid;
  end

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid_c;
  assign bus.inst_pc        = fifo_pc[rd_ptr];
  assign bus.inst_data      = fifo_data[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      pc          <= {RESET_PC[31:2], 2'b00};
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      tag_rd      <= 1'b0;
      tag_wr      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= 32'd0;
        fifo_data[i] <= 32'd0;
        tag_q[i]     <= 32'd0;
      end
    end else begin
      active      <= 1'b1;
      outstanding <= outstanding + {1'b0, req_fire} - {1'b0, bus.imem_rsp_valid};
      if (bus.redirect_valid) begin
        // Anything still in flight belongs to the old path; a response landing now is dropped too.
        pc       <= {bus.redirect_pc[31:2], 2'b00};
        drop_cnt <= outstanding - {1'b0, bus.imem_rsp_valid};
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        tag_rd   <= 1'b0;
        tag_wr   <= 1'b0;
      end else begin
        if (req_fire) begin
          pc            <= pc + 32'd4;
          tag_q[tag_wr] <= pc;
          tag_wr        <= ~tag_wr;
        end
        if (bus.imem_rsp_valid && rsp_drop)
          drop_cnt <= drop_cnt - 2'd1;
        if (push) begin
          fifo_pc[wr_ptr]   <= tag_q[tag_rd];
          fifo_data[wr_ptr] <= bus.imem_rsp_data;
          wr_ptr            <= ~wr_ptr;
          tag_rd            <= ~tag_rd;
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural fixed-latency memory, request/delivery logs, one task per scenario.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int mem_lat = 1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: word at address a is ~a. Fixed latency, in order, one response per cycle at most.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = ~pend[0].addr;
        void'(pend.pop_front());
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend.push_back('{cyc + mem_lat, bus.imem_req_addr});
        req_addr_q.push_back(bus.imem_req_addr);
        req_cyc_q.push_back(cyc);
      end
      if (bus.inst_valid && bus.inst_ready) begin
        got_pc.push_back(bus.inst_pc);
        got_data.push_back(bus.inst_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk)
    if (rst_n)
      assert (dut.count + dut.outstanding <= 2)
        else $error("credit invariant broken: count=%0d outstanding=%0d", dut.count, dut.outstanding);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_cyc_q.delete();
    got_pc.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.inst_ready     = 1'b1;
    bus.imem_req_ready = 1'b1;
    #3;
    clear_logs();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.inst_ready     = 1'b1;
    bus.imem_req_ready = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", bus.imem_req_valid); else n_pass++;
    n_chk++; if (bus.imem_req_addr !== 32'h100) $display("FAIL rst_req_addr got %h want 00000100", bus.imem_req_addr); else n_pass++;
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %b want 0", bus.inst_valid); else n_pass++;
    n_chk++; if (bus.inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %h want 0", bus.inst_pc); else n_pass++;
    n_chk++; if (bus.inst_data !== 32'h0) $display("FAIL rst_inst_data got %h want 0", bus.inst_data); else n_pass++;
    clear_logs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rel_req_valid_early got %b want 0", bus.imem_req_valid); else n_pass++;
    tick(1);
    n_chk++; if (bus.imem_req_valid !== 1'b1) $display("FAIL rel_req_valid got %b want 1", bus.imem_req_valid); else n_pass++;
    n_chk++; if (bus.imem_req_addr !== 32'h100) $display("FAIL rel_req_addr got %h want 00000100", bus.imem_req_addr); else n_pass++;
  endtask

  // Continues straight from test_reset: currently in the first request cycle.
  task automatic test_sequential();
    int a;
    a = cyc;
    tick(12);
    n_chk++; if (req_cyc_q.size() < 1 || req_cyc_q[0] != a) $display("FAIL seq_first_req_cycle got size %0d want cycle %0d", req_cyc_q.size(), a); else n_pass++;
    n_chk++; if (got_pc.size() < 8) $display("FAIL seq_count got %0d want >=8", got_pc.size()); else n_pass++;
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      n_chk++; if (got_pc[i] !== 32'h100 + 32'(4*i)) $display("FAIL seq_pc[%0d] got %h want %h", i, got_pc[i], 32'h100 + 32'(4*i)); else n_pass++;
      n_chk++; if (got_data[i] !== ~(32'h100 + 32'(4*i))) $display("FAIL seq_data[%0d] got %h want %h", i, got_data[i], ~(32'h100 + 32'(4*i))); else n_pass++;
      n_chk++; if (got_cyc[i] != a + 2 + i) $display("FAIL seq_cycle[%0d] got %0d want %0d", i, got_cyc[i], a + 2 + i); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int b;
    do_reset();
    bus.inst_ready = 1'b0;
    tick(1);
    tick(10);
    n_chk++; if (req_addr_q.size() != 2) $display("FAIL bp_req_count got %0d want 2", req_addr_q.size()); else n_pass++;
    n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL bp_req_valid got %b want 0", bus.imem_req_valid); else n_pass++;
    n_chk++; if (bus.inst_valid !== 1'b1) $display("FAIL bp_inst_valid got %b want 1", bus.inst_valid); else n_pass++;
    n_chk++; if (bus.inst_pc !== 32'h100) $display("FAIL bp_head_pc got %h want 00000100", bus.inst_pc); else n_pass++;
    n_chk++; if (got_pc.size() != 0) $display("FAIL bp_no_delivery got %0d want 0", got_pc.size()); else n_pass++;
    bus.inst_ready = 1'b1;
    b = cyc;
    tick(10);
    n_chk++; if (got_pc.size() < 8) $display("FAIL bp_resume_count got %0d want >=8", got_pc.size()); else n_pass++;
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      n_chk++; if (got_pc[i] !== 32'h100 + 32'(4*i)) $display("FAIL bp_pc[%0d] got %h want %h", i, got_pc[i], 32'h100 + 32'(4*i)); else n_pass++;
      n_chk++; if (got_cyc[i] != b + i) $display("FAIL bp_cycle[%0d] got %0d want %0d", i, got_cyc[i], b + i); else n_pass++;
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    tick(1);
    tick(1);
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus.imem_req_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", i, bus.imem_req_valid); else n_pass++;
      n_chk++; if (bus.imem_req_addr !== 32'h104) $display("FAIL stall_addr[%0d] got %h want 00000104", i, bus.imem_req_addr); else n_pass++;
      tick(1);
    end
    n_chk++; if (req_addr_q.size() != 1) $display("FAIL stall_req_count got %0d want 1", req_addr_q.size()); else n_pass++;
    n_chk++; if (got_pc.size() != 1 || got_pc[0] !== 32'h100) $display("FAIL stall_delivered got size %0d want one at 00000100", got_pc.size()); else n_pass++;
    bus.imem_req_ready = 1'b1;
    tick(8);
    n_chk++; if (got_pc.size() < 3 || got_pc[1] !== 32'h104 || got_pc[2] !== 32'h108) $display("FAIL stall_resume got size %0d want 104,108 after 100", got_pc.size()); else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    int a;
    mem_lat = 3;
    do_reset();
    tick(1);
    a = cyc;
    tick(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2003;
    #1;
    n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) $display("FAIL rdi_quiet got inst_valid %b req_valid %b want 0 0", bus.inst_valid, bus.imem_req_valid); else n_pass++;
    tick(1);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    #1;
    n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL rdi_credit_block got %b want 0", bus.imem_req_valid); else n_pass++;
    n_chk++; if (bus.imem_req_addr !== 32'h2000) $display("FAIL rdi_addr_aligned got %h want 00002000", bus.imem_req_addr); else n_pass++;
    tick(15);
    n_chk++; if (req_addr_q.size() < 3 || req_addr_q[2] !== 32'h2000) $display("FAIL rdi_next_req got size %0d want third req at 00002000", req_addr_q.size()); else n_pass++;
    n_chk++; if (req_cyc_q.size() < 3 || req_cyc_q[2] != a + 4) $display("FAIL rdi_next_req_cycle got size %0d want cycle %0d", req_cyc_q.size(), a + 4); else n_pass++;
    n_chk++; if (got_pc.size() < 2 || got_pc[0] !== 32'h2000) $display("FAIL rdi_first_pc got size %0d want first 00002000", got_pc.size()); else n_pass++;
    n_chk++; if (got_pc.size() < 2 || got_pc[1] !== 32'h2004) $display("FAIL rdi_second_pc got size %0d want second 00002004", got_pc.size()); else n_pass++;
    n_chk++; if (got_data.size() < 1 || got_data[0] !== ~32'h2000) $display("FAIL rdi_first_data got size %0d want %h", got_data.size(), ~32'h2000); else n_pass++;
    mem_lat = 1;
  endtask

  task automatic test_redirect_rsp();
    mem_lat = 1;
    do_reset();
    tick(1);
    tick(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    tick(1);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    #1;
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL rdr_empty got %b want 0", bus.inst_valid); else n_pass++;
    n_chk++; if (dut.drop_cnt !== 2'd0) $display("FAIL rdr_drop_cnt got %0d want 0", dut.drop_cnt); else n_pass++;
    n_chk++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h300) $display("FAIL rdr_req got valid %b addr %h want 1 00000300", bus.imem_req_valid, bus.imem_req_addr); else n_pass++;
    tick(1);
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL rdr_gap got %b want 0", bus.inst_valid); else n_pass++;
    tick(1);
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h300) $display("FAIL rdr_target got valid %b pc %h want 1 00000300", bus.inst_valid, bus.inst_pc); else n_pass++;
    n_chk++; if (bus.inst_data !== ~32'h300) $display("FAIL rdr_target_data got %h want %h", bus.inst_data, ~32'h300); else n_pass++;
    n_chk++; if (got_pc.size() != 0) $display("FAIL rdr_stale_delivered got %0d want 0", got_pc.size()); else n_pass++;
  endtask

  task automatic test_async_reset();
    int a;
    mem_lat = 1;
    do_reset();
    tick(6);
    n_chk++; if (bus.inst_valid !== 1'b1) $display("FAIL ar_streaming got %b want 1", bus.inst_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL ar_inst_valid got %b want 0", bus.inst_valid); else n_pass++;
    n_chk++; if (bus.imem_req_valid !== 1'b0) $display("FAIL ar_req_valid got %b want 0", bus.imem_req_valid); else n_pass++;
    n_chk++; if (bus.imem_req_addr !== 32'h100) $display("FAIL ar_req_addr got %h want 00000100", bus.imem_req_addr); else n_pass++;
    clear_logs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick(1);
    a = cyc;
    tick(6);
    n_chk++; if (req_addr_q.size() < 1 || req_addr_q[0] !== 32'h100 || req_cyc_q[0] != a) $display("FAIL ar_restart_req got size %0d want 00000100 at cycle %0d", req_addr_q.size(), a); else n_pass++;
    n_chk++; if (got_pc.size() < 1 || got_pc[0] !== 32'h100 || got_cyc[0] != a + 2) $display("FAIL ar_restart_inst got size %0d want 00000100 at cycle %0d", got_pc.size(), a + 2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_mem_stall();
    test_redirect_inflight();
    test_redirect_rsp();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
